conv_filter_scheduler: RTL and testbench

- Sequences a bank of P parallel convolution engines across all K filters of a layer, one filter set (P filters) per pass.
- Per pass: selects the filter set, holds the engines in reset for one cycle, runs them for a fixed pass length, then presents a capture strobe so the feature-map store can latch the P output maps into bank `filter_set`.
- Sits between the layer-level control (start/abort/done) and the engine pair plus the output feature-map buffer.
- Adds backpressure on capture and abort, and handles K not divisible by P.

---
 rtl/conv_filter_scheduler.sv | 124 ++++++++++++
 tb/tb_conv_filter_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_filter_scheduler.sv
// Steps a bank of P conv engines through every filter set of a layer:
// load set, run a fixed-length pass, then hold a capture request until the store accepts it.
module conv_filter_scheduler #(
  parameter int K           = 6,
  parameter int P           = 2,
  parameter int PASS_CYCLES = 1569,
  parameter int CNT_W       = 16,
  parameter int SET_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [SET_W-1:0] filter_set,
  output logic [P-1:0]     slot_valid,
  output logic             eng_reset,
  output logic             eng_run,
  output logic             cap_valid,
  input  logic             cap_ready,
  output logic [SET_W-1:0] cap_bank,
  output logic [CNT_W-1:0] pass_count
);

  localparam int NUM_SETS = (K + P - 1) / P;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PASS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state;

  assign cap_bank = filter_set;

  // Engines beyond K in a partial final set are masked so their maps are not stored.
  always_comb begin
    int base;
    base       = int'(filter_set) * P;
    slot_valid = '0;
    for (int i = 0; i < P; i++) begin
      slot_valid[i] = (base + i) < K;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      filter_set <= '0;
      eng_reset  <= 1'b1;
      eng_run    <= 1'b0;
      cap_valid  <= 1'b0;
      pass_count <= '0;
    end else if (abort && state != S_IDLE) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      filter_set <= '0;
      eng_reset  <= 1'b1;
      eng_run    <= 1'b0;
      cap_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            filter_set <= '0;
            eng_reset  <= 1'b1;
            pass_count <= '0;
          end
        end
        S_LOAD: begin
          state      <= S_RUN;
          eng_reset  <= 1'b0;
          eng_run    <= 1'b1;
          pass_count <= '0;
        end
        S_RUN: begin
          if (pass_count == LAST_CNT) begin
            state     <= S_CAPTURE;
            eng_run   <= 1'b0;
            cap_valid <= 1'b1;
          end else begin
            pass_count <= pass_count + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          // Engines stay out of reset so their outputs remain valid until the store takes them.
          if (cap_ready) begin
            cap_valid <= 1'b0;
            eng_reset <= 1'b1;
            if (filter_set == LAST_SET) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_LOAD;
              filter_set <= filter_set + SET_W'(1);
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          filter_set <= '0;
          eng_reset  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Drives two schedulers (K=6 and K=5, P=2, 4-cycle passes) from shared stimulus and
// checks them against a set/offset model every cycle, plus literal timing points.
module tb_conv_filter_scheduler;
  localparam int PC = 4;
  localparam int P  = 2;
  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, cap_ready = 1'b1;

  logic       a_busy, a_done, a_er, a_run, a_cv;
  logic [7:0] a_fs, a_cb;
  logic [1:0] a_sv;
  logic [15:0] a_pc;
  logic       b_busy, b_done, b_er, b_run, b_cv;
  logic [7:0] b_fs, b_cb;
  logic [1:0] b_sv;
  logic [15:0] b_pc;

  conv_filter_scheduler #(.K(6), .P(P), .PASS_CYCLES(PC), .CNT_W(16), .SET_W(8)) dut6 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(a_busy), .done(a_done),
    .filter_set(a_fs), .slot_valid(a_sv), .eng_reset(a_er), .eng_run(a_run),
    .cap_valid(a_cv), .cap_ready(cap_ready), .cap_bank(a_cb), .pass_count(a_pc)
  );

  conv_filter_scheduler #(.K(5), .P(P), .PASS_CYCLES(PC), .CNT_W(16), .SET_W(8)) dut5 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(b_busy), .done(b_done),
    .filter_set(b_fs), .slot_valid(b_sv), .eng_reset(b_er), .eng_run(b_run),
    .cap_valid(b_cv), .cap_ready(cap_ready), .cap_bank(b_cb), .pass_count(b_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] expsv(input int k, input int s);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < P; i++) r[i] = (s * P + i) < k;
    return r;
  endfunction

  // Model: a layer is a sequence of sets; within a set, offset 0 is the load cycle,
  // offsets 1..PC are compute cycles, offset PC+1 waits for the store.
  bit m_act = 1'b0, m_dn = 1'b0, m_ok = 1'b0;
  int m_s = 0, m_o = 0;

  always @(posedge clk) begin : model
    bit na, nd;
    int ns, no;
    na = m_act; nd = m_dn; ns = m_s; no = m_o;
    if (reset) begin
      na = 0; nd = 0; ns = 0; no = 0;
    end else if (m_dn) begin
      nd = 0; ns = 0;
    end else if (m_act) begin
      if (abort) begin
        na = 0; ns = 0; no = 0;
      end else if (m_o == PC + 1) begin
        if (cap_ready) begin
          if (m_s == NS - 1) begin
            na = 0; nd = 1;
          end else begin
            ns = m_s + 1; no = 0;
          end
        end
      end else begin
        no = m_o + 1;
      end
    end else if (start && !abort) begin
      na = 1; ns = 0; no = 0;
    end
    m_act <= na;
    m_dn  <= nd;
    m_s   <= ns;
    m_o   <= no;
    m_ok  <= m_ok | reset;
  end

  task automatic cmp(input string id, input int k, input logic busy, input logic done,
                     input logic [7:0] fs, input logic [7:0] cb, input logic er,
                     input logic run, input logic cv, input logic [15:0] pc, input logic [1:0] sv);
    bit e_run, e_cap;
    e_run = m_act && m_o >= 1 && m_o <= PC;
    e_cap = m_act && m_o == PC + 1;
    chk({id, ".busy"}, busy, m_act || m_dn);
    chk({id, ".done"}, done, m_dn);
    chk({id, ".filter_set"}, fs, m_s);
    chk({id, ".cap_bank"}, cb, m_s);
    chk({id, ".eng_reset"}, er, !(m_act && m_o >= 1));
    chk({id, ".eng_run"}, run, e_run);
    chk({id, ".cap_valid"}, cv, e_cap);
    chk({id, ".slot_valid"}, sv, expsv(k, m_s));
    if (e_run) chk({id, ".pass_count"}, pc, m_o - 1);
    if (e_cap) chk({id, ".pass_count_hold"}, pc, PC - 1);
  endtask

  always @(posedge clk) begin : compare
    #1;
    if (m_ok) begin
      cmp("k6", 6, a_busy, a_done, a_fs, a_cb, a_er, a_run, a_cv, a_pc, a_sv);
      cmp("k5", 5, b_busy, b_done, b_fs, b_cb, b_er, b_run, b_cv, b_pc, b_sv);
    end
  end

  int done_at, done_n;
  int cap_n[3], cap_first[3];
  logic [1:0] sv5[3];
  logic ab_busy, ab_er;
  logic [7:0] ab_fs;

  // Cycle n of a layer is the cycle after the n-th edge following the start sample.
  task automatic run_layer(input int last, input int st_from, input int st_to,
                           input int ab_at, input bit spur);
    done_at = 0; done_n = 0;
    for (int b = 0; b < 3; b++) begin
      cap_n[b] = 0; cap_first[b] = 0; sv5[b] = '0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= last; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (a_done) begin
        done_n++; done_at = n;
      end
      if (a_cv && a_cb < 8'd3) begin
        if (cap_n[a_cb] == 0) begin
          cap_first[a_cb] = n;
          sv5[a_cb] = b_sv;
        end
        cap_n[a_cb]++;
      end
      if (n == ab_at + 1) begin
        ab_busy = a_busy; ab_er = a_er; ab_fs = a_fs;
      end
      cap_ready = !(n >= st_from && n <= st_to);
      abort     = (n == ab_at);
      start     = spur && (n == 3 || n == 6 || n == 19);
    end
    start = 1'b0; abort = 1'b0; cap_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", a_busy, 0);
    chk("rst.done", a_done, 0);
    chk("rst.filter_set", a_fs, 0);
    chk("rst.eng_reset", a_er, 1);
    chk("rst.eng_run", a_run, 0);
    chk("rst.cap_valid", a_cv, 0);
    chk("rst.pass_count", a_pc, 0);
    reset = 1'b0;
    step();

    // Free-running store: banks 0,1,2 captured at 6,12,18, done at 19.
    run_layer(20, 0, -1, 0, 0);
    chk("t1.cap0", cap_first[0], 6);
    chk("t1.cap1", cap_first[1], 12);
    chk("t1.cap2", cap_first[2], 18);
    chk("t1.cap_n1", cap_n[1], 1);
    chk("t1.done_at", done_at, 19);
    chk("t1.done_n", done_n, 1);
    chk("t1.busy20", a_busy, 0);
    chk("t3.sv_set0", sv5[0], 2'b11);
    chk("t3.sv_set1", sv5[1], 2'b11);
    chk("t3.sv_set2", sv5[2], 2'b01);
    step();

    // Store stalls three cycles on bank 1.
    run_layer(23, 12, 14, 0, 0);
    chk("t2.cap1_first", cap_first[1], 12);
    chk("t2.cap1_len", cap_n[1], 4);
    chk("t2.cap2", cap_first[2], 21);
    chk("t2.done_at", done_at, 22);
    chk("t2.busy23", a_busy, 0);
    step();

    // Abort in the compute phase of set 1.
    run_layer(40, 0, -1, 9, 0);
    chk("t4.busy", ab_busy, 0);
    chk("t4.eng_reset", ab_er, 1);
    chk("t4.filter_set", ab_fs, 0);
    chk("t4.done_n", done_n, 0);
    chk("t4.cap1_n", cap_n[1], 0);
    run_layer(20, 0, -1, 0, 0);
    chk("t4.redo_done_at", done_at, 19);
    chk("t4.redo_cap2", cap_first[2], 18);
    step();

    // Spurious starts while busy, including the done cycle.
    run_layer(20, 0, -1, 0, 1);
    chk("t5.done_at", done_at, 19);
    chk("t5.done_n", done_n, 1);
    chk("t5.cap1", cap_first[1], 12);
    chk("t5.busy20", a_busy, 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t5.start_abort_idle", a_busy, 0);
    step();
    chk("t5.still_idle", a_busy, 0);

    // Reset during a stalled capture.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("t6.in_capture", a_cv, 1);
    cap_ready = 1'b0;
    step();
    chk("t6.stalled", a_cv, 1);
    reset = 1'b1;
    step();
    chk("t6.busy", a_busy, 0);
    chk("t6.cap_valid", a_cv, 0);
    chk("t6.eng_reset", a_er, 1);
    chk("t6.filter_set", a_fs, 0);
    chk("t6.pass_count", a_pc, 0);
    chk("t6.eng_run", a_run, 0);
    reset = 1'b0; cap_ready = 1'b1;
    step();
    run_layer(20, 0, -1, 0, 0);
    chk("t6.after_done_at", done_at, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
